// File: rtl/cmos_sdram_writer.sv
// cmos_sdram_writer: buffers the RGB565 capture stream in a small FIFO and
// sends it to SDRAM in fixed-length write bursts. Frames are written to two
// banks in turn, so the read side always has a complete frame.
module cmos_sdram_writer #(
  parameter int unsigned BURST_LEN    = 8,
  parameter int unsigned FIFO_DEPTH   = 32,
  parameter int unsigned FRAME_PIXELS = 307200,
  parameter int unsigned ADDR_W       = 22,
  parameter int unsigned BANK_OFFSET  = 32'h0008_0000
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iFRAME_START,
  input  logic [15:0]       iPIX_DATA,
  input  logic              iPIX_VALID,
  output logic              oWR_REQ,
  output logic [ADDR_W-1:0] oWR_ADDR,
  input  logic              iWR_GNT,
  input  logic              iWR_DREQ,
  output logic [15:0]       oWR_DATA,
  output logic              oFRAME_DONE,
  output logic              oBANK,
  output logic              oOVERFLOW
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BEAT_W = $clog2(BURST_LEN);
  localparam int unsigned PIX_W  = $clog2(FRAME_PIXELS + 1);
  localparam logic [ADDR_W-1:0] BANK_BASE = ADDR_W'(BANK_OFFSET);

  if (64'(BANK_OFFSET) + 64'(FRAME_PIXELS) > (64'd1 << ADDR_W)) begin : g_addr_check
    $error("cmos_sdram_writer: BANK_OFFSET + FRAME_PIXELS exceeds ADDR_W");
  end
  if (FIFO_DEPTH < 2 * BURST_LEN) begin : g_depth_check
    $error("cmos_sdram_writer: FIFO_DEPTH must be at least 2*BURST_LEN");
  end

  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;
  state_t state, state_nx;

  logic [15:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, wr_idx;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [PIX_W-1:0]  pix_cnt;
  logic [ADDR_W-1:0] word_off, off_next;
  logic [BEAT_W-1:0] beat;
  logic              wr_bank, pending;
  logic              flush, push, pop, full, frame_room, drop_ovf, last_beat;

  // Datapath decodes shared by the FIFO and the control registers.
  always_comb begin
    flush      = (state == IDLE) && (pending || iFRAME_START);
    pop        = (state == XFER) && iWR_DREQ;
    full       = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    frame_room = (pix_cnt < PIX_W'(FRAME_PIXELS));
    // A pixel arriving with the flush is the first of the new frame, so it
    // bypasses the old full/room state and lands in slot 0.
    push       = iPIX_VALID && (flush || ((!full || pop) && frame_room));
    drop_ovf   = iPIX_VALID && !flush && full && !pop && frame_room;
    wr_idx     = flush ? '0 : wr_ptr;
    last_beat  = pop && (beat == BEAT_W'(BURST_LEN - 1));
    off_next   = word_off + ADDR_W'(BURST_LEN);
  end

  // Pixel storage; contents need no reset since the count gates the head.
  always_ff @(posedge iCLK) begin
    if (push) mem[wr_idx] <= iPIX_DATA;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= push ? PTR_W'(1) : '0;
      fifo_cnt <= push ? CNT_W'(1) : '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      fifo_cnt <= fifo_cnt + CNT_W'(1);
      else if (pop && !push) fifo_cnt <= fifo_cnt - CNT_W'(1);
    end
  end

  // Frame bookkeeping: pixel count, burst offset, beats, banks, flags.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      pix_cnt   <= '0;
      word_off  <= '0;
      beat      <= '0;
      wr_bank   <= 1'b0;
      pending   <= 1'b0;
      oBANK     <= 1'b0;
      oOVERFLOW <= 1'b0;
    end else begin
      if (flush) begin
        pix_cnt   <= push ? PIX_W'(1) : '0;
        word_off  <= '0;
        pending   <= 1'b0;
        oOVERFLOW <= 1'b0;
      end else begin
        if (push)                         pix_cnt   <= pix_cnt + PIX_W'(1);
        if (drop_ovf)                     oOVERFLOW <= 1'b1;
        if (iFRAME_START && state != IDLE) pending  <= 1'b1;
      end
      if (pop) beat <= last_beat ? '0 : beat + BEAT_W'(1);
      if (last_beat) word_off <= off_next;
      if (state == DONE) begin
        word_off <= '0;
        oBANK    <= wr_bank;
        wr_bank  <= ~wr_bank;
      end
    end
  end

  // State register.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= IDLE;
    else         state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (!flush && fifo_cnt >= CNT_W'(BURST_LEN)) state_nx = REQ;
      REQ:  if (iWR_GNT) state_nx = XFER;
      XFER: if (last_beat) state_nx = (off_next == ADDR_W'(FRAME_PIXELS)) ? DONE : IDLE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decoded from state and the FIFO head.
  always_comb begin
    oWR_REQ     = (state == REQ);
    oFRAME_DONE = (state == DONE);
    oWR_ADDR    = (wr_bank ? BANK_BASE : '0) + word_off;
    oWR_DATA    = (fifo_cnt == '0) ? '0 : mem[rd_ptr];
  end

endmodule

// File: tb/tb_cmos_sdram_writer.sv
// Bench for cmos_sdram_writer: a queue-based frame model plus directed and
// randomized stimulus, with every output compared on each falling edge.
module tb_cmos_sdram_writer;

  localparam int unsigned BL    = 8;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned FRAME = 64;
  localparam int unsigned AW    = 22;
  localparam int unsigned BOFF  = 32'h0008_0000;

  logic          iCLK = 1'b0;
  logic          iRST_N = 1'b0;
  logic          iFRAME_START = 1'b0;
  logic [15:0]   iPIX_DATA = '0;
  logic          iPIX_VALID = 1'b0;
  logic          iWR_GNT = 1'b0;
  logic          iWR_DREQ = 1'b0;
  logic          oWR_REQ;
  logic [AW-1:0] oWR_ADDR;
  logic [15:0]   oWR_DATA;
  logic          oFRAME_DONE;
  logic          oBANK;
  logic          oOVERFLOW;

  cmos_sdram_writer #(
    .BURST_LEN(BL), .FIFO_DEPTH(DEPTH), .FRAME_PIXELS(FRAME),
    .ADDR_W(AW), .BANK_OFFSET(BOFF)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iFRAME_START(iFRAME_START),
    .iPIX_DATA(iPIX_DATA), .iPIX_VALID(iPIX_VALID), .oWR_REQ(oWR_REQ),
    .oWR_ADDR(oWR_ADDR), .iWR_GNT(iWR_GNT), .iWR_DREQ(iWR_DREQ),
    .oWR_DATA(oWR_DATA), .oFRAME_DONE(oFRAME_DONE), .oBANK(oBANK),
    .oOVERFLOW(oOVERFLOW)
  );

  always #5 iCLK = ~iCLK;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  int unsigned done_seen = 0;
  bit          cmp_en = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {P_IDLE, P_REQ, P_XFER, P_DONE} phase_e;
  phase_e      m_phase = P_IDLE;
  logic [15:0] m_q[$];
  int unsigned m_pix = 0, m_off = 0, m_beats = 0, m_frames = 0;
  bit          m_wbank = 0, m_rbank = 0, m_ovf = 0, m_pend = 0;

  function automatic logic [AW-1:0] exp_addr();
    return AW'(m_wbank ? BOFF + m_off : m_off);
  endfunction
  function automatic logic [15:0] exp_data();
    return (m_q.size() != 0) ? m_q[0] : 16'h0000;
  endfunction

  task automatic model_step();
    int unsigned old_size = m_q.size();
    bit start_now = (m_phase == P_IDLE) && (m_pend || iFRAME_START);
    bit popping   = (m_phase == P_XFER) && iWR_DREQ;
    if (start_now) begin
      m_q.delete(); m_pix = 0; m_off = 0; m_ovf = 0; m_pend = 0;
    end else if (iFRAME_START) m_pend = 1;
    if (popping) void'(m_q.pop_front());
    if (iPIX_VALID && m_pix < FRAME) begin
      if (m_q.size() < DEPTH) begin m_q.push_back(iPIX_DATA); m_pix++; end
      else m_ovf = 1;
    end
    case (m_phase)
      P_IDLE: if (!start_now && old_size >= BL) m_phase = P_REQ;
      P_REQ:  if (iWR_GNT) begin m_phase = P_XFER; m_beats = 0; end
      P_XFER: if (popping) begin
        m_beats++;
        if (m_beats == BL) begin
          m_off += BL;
          m_phase = (m_off == FRAME) ? P_DONE : P_IDLE;
        end
      end
      P_DONE: begin
        m_rbank = m_wbank; m_wbank = !m_wbank; m_off = 0; m_frames++;
        m_phase = P_IDLE;
      end
      default: m_phase = P_IDLE;
    endcase
  endtask

  initial forever begin
    @(posedge iCLK or negedge iRST_N);
    if (!iRST_N) begin
      m_phase = P_IDLE; m_q.delete(); m_pix = 0; m_off = 0; m_beats = 0;
      m_wbank = 0; m_rbank = 0; m_ovf = 0; m_pend = 0;
    end else model_step();
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge iCLK);
    if (cmp_en) begin
      chk("cyc_req",   oWR_REQ,     m_phase == P_REQ);
      chk("cyc_addr",  oWR_ADDR,    exp_addr());
      chk("cyc_data",  oWR_DATA,    exp_data());
      chk("cyc_done",  oFRAME_DONE, m_phase == P_DONE);
      chk("cyc_bank",  oBANK,       m_rbank);
      chk("cyc_ovf",   oOVERFLOW,   m_ovf);
      if (oFRAME_DONE) done_seen++;
    end
  end

  // ---------------- stimulus helpers ----------------
  int unsigned   gnt_pct = 100, dreq_pct = 100;
  logic [AW-1:0] addr_log[$];

  task automatic step(input bit fs, input bit pv, input logic [15:0] pd,
                      input bit gnt, input bit dreq);
    iFRAME_START = fs; iPIX_VALID = pv; iPIX_DATA = pd;
    iWR_GNT = gnt; iWR_DREQ = dreq;
    @(posedge iCLK); #1;
  endtask

  task automatic auto_step(input bit fs, input bit pv, input logic [15:0] pd);
    bit g, d;
    g = (m_phase == P_REQ)  && ($urandom_range(0, 99) < gnt_pct);
    d = (m_phase == P_XFER) && ($urandom_range(0, 99) < dreq_pct);
    if (g) addr_log.push_back(oWR_ADDR);
    step(fs, pv, pd, g, d);
  endtask

  task automatic drain(input string name);
    int unsigned n = 0;
    while (!(m_phase == P_IDLE && m_q.size() < BL) && n < 400) begin
      auto_step(1'b0, 1'b0, '0);
      n++;
    end
    chk(name, longint'(n < 400), 1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req"},  oWR_REQ, 0);
    chk({tag, "_addr"}, oWR_ADDR, 0);
    chk({tag, "_data"}, oWR_DATA, 0);
    chk({tag, "_done"}, oFRAME_DONE, 0);
    chk({tag, "_bank"}, oBANK, 0);
    chk({tag, "_ovf"},  oOVERFLOW, 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    repeat (2) @(posedge iCLK);
    #1;
    check_all_zero("reset");
    iRST_N = 1'b1;
    cmp_en = 1'b1;

    // 1: first burst, latency and data order
    for (int i = 1; i <= 8; i++) step(0, 1, 16'(i), 0, 0);
    chk("t1_req_latency", oWR_REQ, 0);
    step(0, 0, '0, 0, 0);
    chk("t1_req", oWR_REQ, 1);
    chk("t1_addr", oWR_ADDR, 0);
    step(0, 0, '0, 1, 0);
    chk("t1_req_drop", oWR_REQ, 0);
    for (int k = 1; k <= 8; k++) begin
      chk("t1_beat", oWR_DATA, k);
      step(0, 0, '0, 0, 1);
    end
    chk("t1_empty", oWR_DATA, 0);

    // 2: rest of a 64-pixel frame, then next frame base
    gnt_pct = 100; dreq_pct = 100;
    addr_log.delete();
    for (int i = 9; i <= 64; i++) auto_step(0, 1, 16'(i));
    drain("t2_drain");
    chk("t2_done_count", done_seen, 1);
    chk("t2_bank", oBANK, 0);
    chk("t2_burst_count", addr_log.size(), 7);
    for (int k = 0; k < addr_log.size() && k < 7; k++)
      chk("t2_burst_addr", addr_log[k], (k + 1) * 8);
    step(1, 1, 16'h0100, 0, 0);
    for (int i = 1; i < 8; i++) step(0, 1, 16'h0100 + 16'(i), 0, 0);
    step(0, 0, '0, 0, 0);
    chk("t2_next_req", oWR_REQ, 1);
    chk("t2_next_addr", oWR_ADDR, 22'h080000);
    drain("t2_drain2");

    // 3: overflow with grant withheld
    step(1, 0, '0, 0, 0);
    for (int i = 1; i <= 40; i++) step(0, 1, 16'h3000 + 16'(i), 0, 0);
    chk("t3_ovf", oOVERFLOW, 1);
    chk("t3_model_fill", m_q.size(), 32);
    chk("t3_model_tail", m_q[31], 16'h3020);
    chk("t3_req", oWR_REQ, 1);
    drain("t3_drain");
    chk("t3_ovf_sticky", oOVERFLOW, 1);
    step(1, 0, '0, 0, 0);
    chk("t3_ovf_clear", oOVERFLOW, 0);

    // 4: frame start during a burst
    for (int i = 1; i <= 8; i++) step(0, 1, 16'h4000 + 16'(i), 0, 0);
    step(0, 0, '0, 0, 0);
    chk("t4_req", oWR_REQ, 1);
    step(0, 0, '0, 1, 0);
    for (int b = 1; b <= 8; b++) begin
      chk("t4_beat", oWR_DATA, 16'h4000 + b);
      step(b == 4, b <= 3, 16'h4100 + 16'(b), 0, 1);
    end
    chk("t4_idle_no_req", oWR_REQ, 0);
    chk("t4_head_before_flush", oWR_DATA, 16'h4101);
    step(0, 0, '0, 0, 0);
    chk("t4_flushed", oWR_DATA, 0);
    chk("t4_bank", oBANK, 0);
    chk("t4_no_done", done_seen, 1);
    for (int i = 1; i <= 8; i++) step(0, 1, 16'h4200 + 16'(i), 0, 0);
    step(0, 0, '0, 0, 0);
    chk("t4_restart_addr", oWR_ADDR, 22'h080000);
    drain("t4_drain");

    // 5: push and pop together while full
    step(1, 0, '0, 0, 0);
    for (int i = 1; i <= 32; i++) step(0, 1, 16'h5000 + 16'(i), 0, 0);
    chk("t5_req", oWR_REQ, 1);
    step(0, 0, '0, 1, 0);
    step(0, 1, 16'h5021, 0, 1);
    chk("t5_no_ovf", oOVERFLOW, 0);
    chk("t5_model_count", m_q.size(), 32);
    chk("t5_head", oWR_DATA, 16'h5002);
    drain("t5_drain");
    chk("t5_no_ovf_end", oOVERFLOW, 0);

    // 6: asynchronous reset mid-burst
    step(1, 0, '0, 0, 0);
    for (int i = 1; i <= 8; i++) step(0, 1, 16'h6000 + 16'(i), 0, 0);
    step(0, 0, '0, 0, 0);
    step(0, 0, '0, 1, 0);
    for (int b = 1; b <= 3; b++) step(0, 0, '0, 0, 1);
    iFRAME_START = 0; iPIX_VALID = 0; iWR_GNT = 0; iWR_DREQ = 0;
    #2;
    iRST_N = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(posedge iCLK); #1;
    iRST_N = 1'b1;
    for (int i = 1; i <= 8; i++) step(0, 1, 16'h6100 + 16'(i), 0, 0);
    step(0, 0, '0, 0, 0);
    chk("t6_req", oWR_REQ, 1);
    chk("t6_addr", oWR_ADDR, 0);
    drain("t6_drain");

    // randomized traffic
    gnt_pct = 60; dreq_pct = 80;
    for (int c = 0; c < 4000; c++)
      auto_step($urandom_range(0, 149) == 0, $urandom_range(0, 9) < 7, 16'($urandom));
    gnt_pct = 100; dreq_pct = 100;
    drain("rand_drain");
    chk("rand_frames", done_seen, m_frames);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
